// File: rtl/rom_pkg.sv
// ============================================================================
// Module      : rom_pkg
// Description : Shared types, constants and ROM content function for the
//               burst ROM reader.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package rom_pkg;

  // Burst engine states
  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_READ = 1'b1
  } state_t;

  // ROM content selection
  localparam int ROM_DESC = 0;
  localparam int ROM_ASC  = 1;

  // Word stored at address a. Descending content needs the table depth,
  // which defaults to the legacy 16-entry table.
  function automatic logic [31:0] rom_init(input int unsigned a,
                                           input int          mode,
                                           input int unsigned depth = 16);
    if (mode == ROM_ASC) begin
      return a;
    end
    return depth - 1 - a;
  endfunction

endpackage

`default_nettype wire

// File: rtl/rom_sync_core.sv
// ============================================================================
// Module      : rom_sync_core
// Description : Synchronous-read ROM array, DEPTH x DATA_W, contents built
//               from rom_init. Read data updates only when rd_en is high.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module rom_sync_core
  import rom_pkg::*;
#(
  parameter int DATA_W    = 16,
  parameter int ADDR_W    = 4,
  parameter int INIT_MODE = ROM_DESC
) (
  input  logic              clk,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data
);

  localparam int DEPTH = 2 ** ADDR_W;

  logic [DATA_W-1:0] w_mem [DEPTH];

  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_word
      assign w_mem[gi] = DATA_W'(rom_init(gi, INIT_MODE, DEPTH));
    end
  endgenerate

  // Registered read port; holds its word while rd_en is low
  always_ff @(posedge clk) begin
    if (rd_en) begin
      rd_data <= w_mem[rd_addr];
    end
  end

endmodule

`default_nettype wire

// File: rtl/rom_burst_reader.sv
// ============================================================================
// Module      : rom_burst_reader
// Description : Parametrised ROM with a burst-read engine. One start command
//               streams burst_len consecutive words from base_addr over a
//               valid/ready port with address wrap, back-pressure, a last
//               marker and a done pulse.
//               Optional macro ROM_BURST_PARITY_EN adds out_parity, the XOR
//               reduction of the word held in out_data.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module rom_burst_reader
  import rom_pkg::*;
#(
  parameter int DATA_W    = 16,
  parameter int ADDR_W    = 4,
  parameter int INIT_MODE = ROM_DESC
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W:0]   burst_len,
  output logic              busy,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_last,
`ifdef ROM_BURST_PARITY_EN
  output logic              out_parity,
`endif
  output logic              done
);

  localparam int DEPTH = 2 ** ADDR_W;
  localparam logic [ADDR_W:0] c_DEPTH_LEN = (ADDR_W + 1)'(DEPTH);
  localparam logic [ADDR_W:0] c_ONE_LEN   = (ADDR_W + 1)'(1);

  state_t            r_state;
  state_t            w_state_next;
  logic [ADDR_W-1:0] r_addr;
  logic [ADDR_W:0]   r_rem;
  logic              r_valid;
  logic              r_last;
  logic              r_done;
  logic              r_loaded;
  logic [DATA_W-1:0] w_rd_data;
  logic [ADDR_W:0]   w_len_clamped;
  logic              w_start_ok;
  logic              w_issue;
  logic              w_hs;
  logic              w_finish;

  // Oversize requests are clamped to one full pass of the table
  assign w_len_clamped = (burst_len > c_DEPTH_LEN) ? c_DEPTH_LEN : burst_len;
  assign w_start_ok    = (r_state == ST_IDLE) && start && (burst_len != '0);
  assign w_hs          = r_valid && out_ready;
  assign w_finish      = (r_state == ST_READ) && w_hs && r_last;
  // A new word may be fetched only when the output slot is free or draining
  assign w_issue       = (r_state == ST_READ) && en && (r_rem != '0) &&
                         (!r_valid || out_ready);

  rom_sync_core #(
    .DATA_W    (DATA_W),
    .ADDR_W    (ADDR_W),
    .INIT_MODE (INIT_MODE)
  ) u_core (
    .clk     (clk),
    .rd_en   (w_issue),
    .rd_addr (r_addr),
    .rd_data (w_rd_data)
  );

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state logic: leave READ only when the last beat is accepted
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE: if (w_start_ok) w_state_next = ST_READ;
      ST_READ: if (w_finish)   w_state_next = ST_IDLE;
      default: w_state_next = ST_IDLE;
    endcase
  end

  // Burst address and remaining-word counters
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_addr <= '0;
      r_rem  <= '0;
    end else if (w_start_ok) begin
      r_addr <= base_addr;
      r_rem  <= w_len_clamped;
    end else if (w_issue) begin
      r_addr <= r_addr + 1'b1;
      r_rem  <= r_rem - 1'b1;
    end
  end

  // Output handshake flags and done pulse
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid  <= 1'b0;
      r_last   <= 1'b0;
      r_done   <= 1'b0;
      r_loaded <= 1'b0;
    end else begin
      r_done <= w_finish;
      if (w_issue) begin
        r_valid  <= 1'b1;
        r_last   <= (r_rem == c_ONE_LEN);
        r_loaded <= 1'b1;
      end else if (w_hs) begin
        r_valid <= 1'b0;
        r_last  <= 1'b0;
      end
    end
  end

  // The core array has no reset; r_loaded forces the word to zero until the
  // first fetch after reset.
  assign out_data  = r_loaded ? w_rd_data : '0;
  assign out_valid = r_valid;
  assign out_last  = r_last;
  assign busy      = (r_state == ST_READ);
  assign done      = r_done;

`ifdef ROM_BURST_PARITY_EN
  // Derived from the registered word, so it holds exactly as out_data does
  assign out_parity = ^out_data;
`endif

endmodule

`default_nettype wire

// File: doc/rom_burst_reader.md
Name: rom_burst_reader

Overview:
- Parametrised successor of the team's fixed 16x16 lookup ROM: synchronous ROM of DEPTH words x DATA_W bits with a burst-read engine.
- A single start command streams burst_len consecutive words from base_addr over a valid/ready output, with address wrap-around, back-pressure and a done pulse.
- Sits between control FSMs and datapath consumers that need table sequences rather than single lookups.

Parameters:
- DATA_W, 16, output word width.
- ADDR_W, 4, address width; DEPTH = 2**ADDR_W (localparam).
- INIT_MODE, 0, contents: 0 = descending, mem[a] = DEPTH-1-a; 1 = ascending, mem[a] = a. Both truncated/zero-extended to DATA_W.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- en  in  1  global enable; low freezes the issue of new reads
- start  in  1  burst request, sampled in IDLE only
- base_addr  in  ADDR_W  first address of the burst
- burst_len  in  ADDR_W+1  number of words, 1..DEPTH
- busy  out  1  high while state is READ
- out_data  out  DATA_W  registered ROM word
- out_valid  out  1  out_data valid
- out_ready  in  1  consumer accepts
- out_last  out  1  marks the final beat of the burst
- done  out  1  one-cycle pulse after the last beat is accepted

Behaviour:
- Reset: all outputs 0, state IDLE, internal address and remaining counters 0. Reset is asynchronous, so asserting it mid-burst aborts immediately; no done pulse is generated.
- FSM is two states, IDLE and READ.
- IDLE to READ: start=1 and burst_len != 0.
  - Latch addr = base_addr.
  - Latch rem = min(burst_len, DEPTH); oversize lengths are clamped.
  - The en level is irrelevant to this transition.
- start with burst_len=0 is ignored; no busy, no done.
- start in READ is ignored.
- Issue condition (READ state): en && rem != 0 && (!out_valid || out_ready). On each issue, at the next edge:
  - out_data <= mem[addr]
  - out_valid <= 1
  - out_last <= (rem == 1)
  - addr <= addr + 1 mod DEPTH (wraps DEPTH-1 to 0)
  - rem <= rem - 1
- If there is no issue and out_valid && out_ready, then out_valid <= 0 and out_last <= 0.
- Valid stability: while out_valid && !out_ready, out_data and out_last stay constant, including when en is low.
- Throughput: 1 word/cycle when out_ready=1 and en=1. Latency: the start cycle is followed by one cycle in READ, and the first beat is valid in the second cycle after the start cycle.
- READ to IDLE: on a handshake where out_last=1. At that same edge, done <= 1 for exactly one cycle and busy <= 0. A new start is accepted in the cycle done is high.
- en low in READ: no new issues and the burst is held; a pending valid beat can still be accepted.

Optional Feature:
- Macro: ROM_BURST_PARITY_EN.
- When defined: adds output port out_parity (1 bit), the even parity (XOR reduction) of the word loaded into out_data. It is registered alongside out_data, resets to 0, and follows the same hold rule.
- When undefined: the port and its logic are absent; all other behaviour is identical.

Decomposition:
- Shared package rom_pkg holds:
  - the state enum (ST_IDLE, ST_READ)
  - the INIT_MODE constants (ROM_DESC = 0, ROM_ASC = 1)
  - a function rom_init(a, mode) returning the word content
- One natural sub-module, rom_sync_core. It is a pure synchronous ROM array with inputs clk, rd_en, rd_addr and output rd_data, contents built via rom_init. The burst FSM, counters and handshake stay in the top.

Test Plan:
- Defaults, out_ready=1, en=1, start with base_addr=0, burst_len=4 -> out_data 15,14,13,12 on consecutive cycles; out_last only on 12; done pulses on the cycle after the 12 handshake; busy is 0 afterwards.
- Wrap: base_addr=14, burst_len=4 -> 1,0,15,14.
- Clamp: burst_len=20 -> 16 beats.
- Zero length: burst_len=0 -> no busy, no valid, no done.
- Back-pressure: out_ready toggled 1,0,0,1,... during base_addr=5, burst_len=3 -> every beat delivered once, in order 10,9,8. out_data/out_last stable while stalled. No duplicates or drops.
- en and restart: en=0 for 3 cycles mid-burst -> issue pauses and the held beat is still accepted. start pulsed while busy -> ignored. Second start in the done cycle -> accepted.
- Reset mid-burst: rst_n low after 2 of 8 beats -> all outputs 0 asynchronously, state IDLE, no done. The next burst behaves from a clean state. With ROM_BURST_PARITY_EN defined: word 7 (0x0007) -> out_parity=1, word 12 (0x000C) -> 0.
